alu_pipe: RTL

Parametrised, registered successor of the processor's combinational ALU. It executes the same 4-bit operation set on WIDTH-bit operands behind a valid/ready handshake, and adds status flags, a pass-through tag and an optional iterative multiplier. It sits between operand fetch and writeback in the multi-cycle datapath.

---
 rtl/alu_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, status flags and a pass-through tag.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for opcode 14.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_illegal
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SHL_U = 4'd3;
    localparam logic [3:0] OP_SHR_U = 4'd4;
    localparam logic [3:0] OP_SHL_S = 4'd5;
    localparam logic [3:0] OP_SHR_S = 4'd6;
    localparam logic [3:0] OP_LT    = 4'd7;
    localparam logic [3:0] OP_EQ    = 4'd8;
    localparam logic [3:0] OP_NEQ   = 4'd9;
    localparam logic [3:0] OP_AND   = 4'd10;
    localparam logic [3:0] OP_OR    = 4'd11;
    localparam logic [3:0] OP_XOR   = 4'd12;
    localparam logic [3:0] OP_NOR   = 4'd13;
    localparam logic [3:0] OP_LT_S  = 4'd15;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic             illegal;
    } alu_res_t;

    // Single-cycle operations; opcode 14 lands in default and is handled by the multiplier when built.
    function automatic alu_res_t alu_calc(input logic [3:0] op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic        [WIDTH:0]   wide;
        logic        [SH_W-1:0]  sh;
        alu_res_t                r;
        sa   = $signed(a);
        sb   = $signed(b);
        sh   = b[SH_W-1:0];
        wide = '0;
        r    = '0;
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                r.result = wide[WIDTH-1:0];
                r.carry  = wide[WIDTH];
                r.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (r.result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r.result = a - b;
                r.carry  = (a >= b);
                r.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (r.result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL_U, OP_SHL_S: r.result = a << sh;
            OP_SHR_U:           r.result = a >> sh;
            OP_SHR_S:           r.result = sa >>> sh;
            OP_LT:              r.result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_LT_S:            r.result = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_EQ:              r.result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_NEQ:             r.result = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_AND:             r.result = a & b;
            OP_OR:              r.result = a | b;
            OP_XOR:             r.result = a ^ b;
            OP_NOR:             r.result = ~(a | b);
            default:            r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    alu_res_t alu_p0;
    logic     idle;
    logic     res_free;
    logic     accept;
    logic     mul_req;
    logic     load_alu;

    always_comb alu_p0 = alu_calc(in_op, in_a, in_b);

    assign res_free = !out_valid || out_ready;
    assign in_ready = idle && res_free;
    assign accept   = in_valid && in_ready;
    assign load_alu = accept && !mul_req;

`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mul_a_p1;
    logic [WIDTH-1:0] mul_b_p1;
    logic [WIDTH-1:0] acc_p1;
    logic [TAG_W-1:0] mul_tag_p1;
    logic [WIDTH-1:0] acc_next;
    logic             mul_done;

    assign idle     = (state == S_IDLE);
    assign mul_req  = (in_op == OP_MUL);
    assign acc_next = mul_b_p1[0] ? acc_p1 + mul_a_p1 : acc_p1;
    // The final partial sum is recomputed each cycle while waiting, so acc never double-adds.
    assign mul_done = (state == S_MUL) && (cnt == CNT_LAST) && res_free;

    // Stage p1: operand shift registers and partial product
    always_ff @(posedge clk) begin
        if (accept && mul_req) begin
            mul_a_p1   <= in_a;
            mul_b_p1   <= in_b;
            acc_p1     <= '0;
            mul_tag_p1 <= in_tag;
        end else if (state == S_MUL && cnt != CNT_LAST) begin
            acc_p1   <= acc_next;
            mul_a_p1 <= mul_a_p1 << 1;
            mul_b_p1 <= mul_b_p1 >> 1;
        end
    end
`else
    assign idle    = 1'b1;
    assign mul_req = 1'b0;
`endif

    // Stage p2: result registers and control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state       <= S_IDLE;
            cnt         <= '0;
`endif
        end else begin
            if (load_alu) begin
                out_valid   <= 1'b1;
                out_result  <= alu_p0.result;
                out_tag     <= in_tag;
                out_zero    <= (alu_p0.result == '0);
                out_neg     <= alu_p0.result[WIDTH-1];
                out_carry   <= alu_p0.carry;
                out_ovf     <= alu_p0.ovf;
                out_illegal <= alu_p0.illegal;
`ifdef ALU_PIPE_MUL_EN
            end else if (mul_done) begin
                out_valid   <= 1'b1;
                out_result  <= acc_next;
                out_tag     <= mul_tag_p1;
                out_zero    <= (acc_next == '0);
                out_neg     <= acc_next[WIDTH-1];
                out_carry   <= 1'b0;
                out_ovf     <= 1'b0;
                out_illegal <= 1'b0;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

`ifdef ALU_PIPE_MUL_EN
            case (state)
                S_IDLE: begin
                    if (accept && mul_req) begin
                        state <= S_MUL;
                        cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (res_free) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end
endmodule
